pc: RTL and testbench
=====================

PC -- requirements
Module: pc

Interface
- REQ-001: Parameter: WIDTH, 32, address width in bits.
- REQ-002: Parameter: RESET_VECTOR, 32'h0000_0000, value loaded into out by reset.
- REQ-003: Clock and reset: one clock; reset is asynchronous and active-high. The ports SHALL be named clk and rst.
- REQ-004: Port: clk  input  1  rising-edge clock; all state SHALL update on it.
- REQ-005: Port: rst  input  1  asynchronous, active-high reset.
- REQ-006: Port: in  input  WIDTH  next program-counter value.
- REQ-007: Port: out  output  WIDTH  current program-counter value, driven directly from a register.
- REQ-008: Port: pc_plus4  output  WIDTH  out + 4, combinational.

Function
- REQ-009: Each rising clk edge with rst low, out SHALL load in; latency is exactly one edge.
- REQ-010: out SHALL hold its value between edges; changes on in between edges SHALL NOT affect out until the next rising edge.
- REQ-011: No enable or stall exists; every rising edge with rst low SHALL load in.
- REQ-012: pc_plus4 SHALL equal out + 4 modulo 2^WIDTH; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000 with no carry out.
- REQ-013: in containing X or Z at an edge SHALL propagate to out without any substitution logic.

Reset
- REQ-014: rst high SHALL force out to RESET_VECTOR immediately, without waiting for a clk edge.
- REQ-015: While rst is high, out SHALL stay RESET_VECTOR regardless of clk and in.
- REQ-016: On rst deassertion, the first rising edge SHALL load in.
- REQ-017: pc_plus4 SHALL read RESET_VECTOR + 4 during reset.
- REQ-018: misaligned (see REQ-019) SHALL be 0 during reset.

Configuration
- REQ-019: Macro PC_ALIGN_CHECK_EN, when defined:
  - adds output misaligned (1 bit, registered);
  - each load SHALL store in with bits [1:0] forced to 0;
  - misaligned SHALL be set to 1 on that same edge when in[1:0] != 0, otherwise 0.
- REQ-020: Without PC_ALIGN_CHECK_EN:
  - no misaligned port;
  - out SHALL load in verbatim, including bits [1:0].

Structure
- REQ-021: Shared package pc_pkg SHALL hold:
  - PC_WIDTH = 32;
  - PC_RESET_VECTOR default;
  - INSTR_BYTES = 4;
  - typedef pc_t (PC_WIDTH-bit address).
- REQ-022: The increment SHALL be a sub-module pc_inc (WIDTH-bit adder of constant INSTR_BYTES).
- REQ-023: pc SHALL contain the register, reset logic, optional alignment logic and one pc_inc instance.

Verification
- REQ-024: Hold rst=1, in=0, no clk edges -> out=0, pc_plus4=4.
- REQ-025: Release rst. Set in=10 after a rising edge, then apply the next rising edge -> out stays 0 until that edge, then out=10, pc_plus4=14. Without the macro, out=10 also holds on the two following edges with in unchanged.
- REQ-026: Load in=32'h0040_0000. Assert rst mid-cycle with no clk edge -> out=0 immediately. Deassert rst, next edge -> out=32'h0040_0000.
- REQ-027: Load in=32'hFFFF_FFFC -> out=32'hFFFF_FFFC, pc_plus4=32'h0000_0000.
- REQ-028: With PC_ALIGN_CHECK_EN, load in=32'h0000_0013 -> out=32'h0000_0010, misaligned=1. Next edge with in=32'h0000_0014 -> out=32'h0000_0014, misaligned=0.
- REQ-029: RESET_VECTOR=32'hBFC0_0000 with rst pulsed -> out=32'hBFC0_0000, pc_plus4=32'hBFC0_0004.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter slice.
//   PC_WIDTH        - address width in bits
//   PC_RESET_VECTOR - default value loaded into the PC by reset
//   INSTR_BYTES     - fixed instruction size, used as the PC increment
//   pc_t            - PC_WIDTH-bit address type
package pc_pkg;

  localparam int unsigned PC_WIDTH    = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef logic [PC_WIDTH-1:0] pc_t;

  localparam pc_t PC_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_inc.sv
// pc_inc: WIDTH-bit adder of the constant INSTR_BYTES.
// Ports:
//   a - input address
//   y - a + INSTR_BYTES, modulo 2^WIDTH (carry out discarded)
module pc_inc
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a + WIDTH'(INSTR_BYTES);
  end

endmodule

// File: rtl/pc.sv
// pc: program-counter register with combinational next-sequential address.
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous, active-high reset; forces out to RESET_VECTOR
//   in         - next PC value, loaded on every rising edge outside reset
//   out        - current PC, driven directly from the register
//   pc_plus4   - out + 4, combinational, wraps modulo 2^WIDTH
//   misaligned - (PC_ALIGN_CHECK_EN only) registered flag, set when the
//                loaded value had nonzero bits [1:0]
// Build option: define PC_ALIGN_CHECK_EN to force bits [1:0] of every load
// to zero and add the misaligned output.
module pc
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH        = PC_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] pc_plus4
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             misaligned
`endif
);

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out        <= RESET_VECTOR;
      misaligned <= 1'b0;
    end else begin
      out        <= {in[WIDTH-1:2], 2'b00};
      misaligned <= |in[1:0];
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= RESET_VECTOR;
    end else begin
      out <= in;
    end
  end
`endif

  pc_inc #(
    .WIDTH (WIDTH)
  ) u_inc (
    .a (out),
    .y (pc_plus4)
  );

endmodule

// File: tb/tb_pc.sv
module tb_pc;

  logic        clk;
  logic        rst;
  logic [31:0] in;
  logic [31:0] out, pc_plus4;
  logic [31:0] out_bv, pc_plus4_bv;
`ifdef PC_ALIGN_CHECK_EN
  logic        misaligned, misaligned_bv;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: what the PC must hold, by the rules, at any moment.
  logic [31:0] exp_pc, exp_bv;
  logic        exp_mis;

  localparam logic [31:0] RV_BV = 32'hBFC0_0000;

  pc u_dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .out      (out),
    .pc_plus4 (pc_plus4)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misaligned (misaligned)
`endif
  );

  pc #(
    .RESET_VECTOR (32'hBFC0_0000)
  ) u_bv (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .out      (out_bv),
    .pc_plus4 (pc_plus4_bv)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misaligned (misaligned_bv)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] stored(input logic [31:0] x);
`ifdef PC_ALIGN_CHECK_EN
    return x & ~32'd3;
`else
    return x;
`endif
  endfunction

  // Model update: a clock edge outside reset captures in.
  always @(posedge clk) begin
    if (!rst) begin
      exp_pc  = stored(in);
      exp_bv  = stored(in);
      exp_mis = (in % 4) != 0;
    end
  end

  task automatic set_rst(input logic v);
    rst = v;
    if (v) begin
      exp_pc  = 32'h0;
      exp_bv  = RV_BV;
      exp_mis = 1'b0;
    end
  endtask

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("out",          out,          exp_pc);
    chk("pc_plus4",     pc_plus4,     exp_pc + 32'd4);
    chk("out_bv",       out_bv,       exp_bv);
    chk("pc_plus4_bv",  pc_plus4_bv,  exp_bv + 32'd4);
`ifdef PC_ALIGN_CHECK_EN
    chk("misaligned",   {31'd0, misaligned},    {31'd0, exp_mis});
    chk("misaligned_bv",{31'd0, misaligned_bv}, {31'd0, exp_mis});
`endif
  end

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in      = 32'h0;
    rst     = 1'b0;
    set_rst(1'b1);
    #1;
    // Reset with no clock edge yet.
    chk("rst_out",     out,         32'h0000_0000);
    chk("rst_plus4",   pc_plus4,    32'h0000_0004);
    chk("rst_bv_out",  out_bv,      32'hBFC0_0000);
    chk("rst_bv_plus4",pc_plus4_bv, 32'hBFC0_0004);
`ifdef PC_ALIGN_CHECK_EN
    chk("rst_mis",     {31'd0, misaligned}, 32'd0);
`endif
    edge_step();
    chk("rst_hold_out", out, 32'h0000_0000);
    set_rst(1'b0);
    in = 32'd10;
    #2;
    chk("pre_edge_out", out, 32'h0000_0000);
    edge_step();
`ifdef PC_ALIGN_CHECK_EN
    chk("load10_out",   out,      32'h0000_0008);
    chk("load10_plus4", pc_plus4, 32'h0000_000C);
    chk("load10_mis",   {31'd0, misaligned}, 32'd1);
`else
    chk("load10_out",   out,      32'd10);
    chk("load10_plus4", pc_plus4, 32'd14);
    edge_step();
    chk("hold10_a",     out,      32'd10);
    edge_step();
    chk("hold10_b",     out,      32'd10);
`endif

    in = 32'h0040_0000;
    edge_step();
    chk("load400k", out, 32'h0040_0000);
    #1;
    set_rst(1'b1);
    #1;
    chk("async_rst_out",   out,         32'h0000_0000);
    chk("async_rst_bv",    out_bv,      32'hBFC0_0000);
    chk("async_rst_bv_p4", pc_plus4_bv, 32'hBFC0_0004);
    #1;
    set_rst(1'b0);
    edge_step();
    chk("post_rst_load", out, 32'h0040_0000);

    in = 32'hFFFF_FFFC;
    edge_step();
    chk("wrap_out",   out,      32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0000_0000);

`ifdef PC_ALIGN_CHECK_EN
    in = 32'h0000_0013;
    edge_step();
    chk("align13_out", out, 32'h0000_0010);
    chk("align13_mis", {31'd0, misaligned}, 32'd1);
    in = 32'h0000_0014;
    edge_step();
    chk("align14_out", out, 32'h0000_0014);
    chk("align14_mis", {31'd0, misaligned}, 32'd0);
`endif

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int unsigned i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0:       in = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
        1:       in = 32'($urandom_range(0, 15));
        default: in = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) begin
        #2;
        set_rst(1'b1);
        #1;
        chk("rnd_async_rst", out, 32'h0000_0000);
        if ($urandom_range(0, 1) == 1) begin
          @(posedge clk);
          #2;
        end
        set_rst(1'b0);
      end
      edge_step();
    end

    #10;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
